// File: rtl/bus_arbiter.sv
// Two-master serial bus arbiter with hold timeout and combinational line muxing.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise master 0 wins ties.
module bus_arbiter #(
   parameter int unsigned TIMEOUT = 256
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req_i,
   output logic [1:0] grant_o,
   input  logic [1:0] m_wr_bus_i,
   input  logic [1:0] m_mode_i,
   input  logic [1:0] m_valid_i,
   output logic [1:0] m_rd_bus_o,
   output logic [1:0] m_ready_o,
   output logic       wr_bus_o,
   output logic       mode_o,
   output logic       master_valid_o,
   input  logic       rd_bus_i,
   input  logic       slave_ready_i,
   output logic       timeout_o,
   output logic       timeout_id_o
);

   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CMAX = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   state_t        state_q, state_d;
   logic [1:0]    grant_q, grant_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    mask_q, mask_d;
   logic          tout_q, tout_d;
   logic          tid_q, tid_d;
   logic [1:0]    eff_req;
   logic          win;
   logic          gidx;

`ifdef BUS_ARB_ROUND_ROBIN_EN
   logic          last_q, last_d;

   // On a tie the master that did not win last time goes first.
   always_comb begin
      win = eff_req[1];
      if (eff_req == 2'b11) win = ~last_q;
   end
`else
   always_comb win = ~eff_req[0];
`endif

   assign eff_req = req_i & ~mask_q;
   assign gidx    = grant_q[1];

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      cnt_d   = cnt_q;
      tout_d  = 1'b0;
      tid_d   = tid_q;
      mask_d  = mask_q & req_i;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      last_d  = last_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (|eff_req) begin
               grant_d = win ? 2'b10 : 2'b01;
               cnt_d   = '0;
               state_d = GRANT;
`ifdef BUS_ARB_ROUND_ROBIN_EN
               last_d  = win;
`endif
            end
         end
         GRANT: begin
            cnt_d = cnt_q + 1'b1;
            // A dropped request takes precedence over an expiring counter.
            if (!req_i[gidx]) begin
               grant_d = 2'b00;
               state_d = RELEASE;
            end else if (cnt_q == CMAX) begin
               grant_d      = 2'b00;
               state_d      = RELEASE;
               tout_d       = 1'b1;
               tid_d        = gidx;
               mask_d[gidx] = 1'b1;
            end
         end
         RELEASE: begin
            grant_d = 2'b00;
            state_d = IDLE;
         end
         default: begin
            grant_d = 2'b00;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         grant_q <= 2'b00;
         cnt_q   <= '0;
         mask_q  <= 2'b00;
         tout_q  <= 1'b0;
         tid_q   <= 1'b0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
         last_q  <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         tout_q  <= tout_d;
         tid_q   <= tid_d;
`ifdef BUS_ARB_ROUND_ROBIN_EN
         last_q  <= last_d;
`endif
      end
   end

   assign grant_o        = grant_q;
   assign timeout_o      = tout_q;
   assign timeout_id_o   = tid_q;
   assign wr_bus_o       = |(grant_q & m_wr_bus_i);
   assign mode_o         = |(grant_q & m_mode_i);
   assign master_valid_o = |(grant_q & m_valid_i);
   assign m_rd_bus_o     = grant_q & {2{rd_bus_i}};
   assign m_ready_o      = grant_q & {2{slave_ready_i}};

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with TIMEOUT=8.
// Tie expectations follow BUS_ARB_ROUND_ROBIN_EN when defined.
module tb_bus_arbiter;

   logic       clk;
   logic       rst;
   logic [1:0] req;
   logic [1:0] m_wr;
   logic [1:0] m_mode;
   logic [1:0] m_valid;
   logic       rd_bus;
   logic       s_rdy;
   logic [1:0] grant;
   logic [1:0] m_rd;
   logic [1:0] m_rdy;
   logic       wr_bus;
   logic       mode;
   logic       mvalid;
   logic       tout;
   logic       tid;

   int cmps = 0;
   int errs = 0;

   logic [23:0] wstream;
   logic [7:0]  rstream;

   bus_arbiter #(.TIMEOUT(8)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .req_i          (req),
      .grant_o        (grant),
      .m_wr_bus_i     (m_wr),
      .m_mode_i       (m_mode),
      .m_valid_i      (m_valid),
      .m_rd_bus_o     (m_rd),
      .m_ready_o      (m_rdy),
      .wr_bus_o       (wr_bus),
      .mode_o         (mode),
      .master_valid_o (mvalid),
      .rd_bus_i       (rd_bus),
      .slave_ready_i  (s_rdy),
      .timeout_o      (tout),
      .timeout_id_o   (tid)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      cmps++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; req = 2'b00; m_wr = 2'b00; m_mode = 2'b00;
      m_valid = 2'b00; rd_bus = 1'b0; s_rdy = 1'b0;
      wstream = 24'hF2345A;
      rstream = 8'hC3;
      step();
      chk("rst_grant", {6'd0, grant}, 8'd0);
      chk("rst_tout", {7'd0, tout}, 8'd0);
      chk("rst_tid", {7'd0, tid}, 8'd0);
      chk("rst_mux", {5'd0, wr_bus, mode, mvalid}, 8'd0);
      chk("rst_ret", {4'd0, m_rd, m_rdy}, 8'd0);
      rst = 1'b0;
      step();

      // single master write
      req = 2'b01;
      step();
      chk("single_grant", {6'd0, grant}, 8'h01);
      m_mode = 2'b01; m_valid = 2'b01; rd_bus = 1'b1; s_rdy = 1'b1;
      for (int i = 0; i < 24; i++) begin
         m_wr = {~wstream[23-i], wstream[23-i]};
         #2;
         chk("wr_bit", {7'd0, wr_bus}, {7'd0, wstream[23-i]});
      end
      chk("wr_mode", {6'd0, mode, mvalid}, 8'h03);
      chk("wr_ret", {4'd0, m_rd, m_rdy}, 8'h05);
      step(); step();
      req = 2'b00;
      step();
      chk("single_rel", {6'd0, grant}, 8'h00);
      chk("rel_mux", {5'd0, wr_bus, mode, mvalid}, 8'd0);
      chk("rel_ret", {4'd0, m_rd, m_rdy}, 8'd0);
      step();

      // master 1 read return path
      req = 2'b10; m_mode = 2'b01; m_valid = 2'b11; m_wr = 2'b01;
      step();
      chk("read_grant", {6'd0, grant}, 8'h02);
      chk("read_mux", {5'd0, wr_bus, mode, mvalid}, 8'h01);
      for (int i = 0; i < 8; i++) begin
         rd_bus = rstream[7-i];
         s_rdy  = i[0];
         #2;
         chk("rd_bus", {6'd0, m_rd}, {6'd0, rstream[7-i], 1'b0});
         chk("rd_rdy", {6'd0, m_rdy}, {6'd0, i[0], 1'b0});
      end
      req = 2'b00;
      step();
      chk("read_rel", {6'd0, grant}, 8'h00);
      step();

      // tie handling
      req = 2'b11;
      step();
      chk("tie_first", {6'd0, grant}, 8'h01);
      step(); step(); step();
      chk("tie_hold", {6'd0, grant}, 8'h01);
      req = 2'b10;
      step();
      chk("tie_rel0", {6'd0, grant}, 8'h00);
      req = 2'b11;
      step();
      chk("tie_idle0", {6'd0, grant}, 8'h00);
      step();
`ifdef BUS_ARB_ROUND_ROBIN_EN
      chk("tie_second", {6'd0, grant}, 8'h02);
      step(); step(); step();
      req = 2'b01;
      step();
      chk("tie_rel1", {6'd0, grant}, 8'h00);
      req = 2'b11;
      step(); step();
      chk("tie_third", {6'd0, grant}, 8'h01);
`else
      chk("tie_second", {6'd0, grant}, 8'h01);
      req = 2'b10;
      step();
      chk("tie_rel1", {6'd0, grant}, 8'h00);
      step();
      chk("tie_idle1", {6'd0, grant}, 8'h00);
      step();
      chk("tie_third", {6'd0, grant}, 8'h02);
`endif
      req = 2'b00;
      step(); step();
      chk("tie_done", {6'd0, grant}, 8'h00);

      // timeout of master 0 with master 1 pending
      req = 2'b01;
      step();
      req = 2'b11;
      for (int i = 0; i < 8; i++) begin
         chk("to_hold", {6'd0, grant}, 8'h01);
         chk("to_nopulse", {7'd0, tout}, 8'd0);
         step();
      end
      chk("to_revoke", {6'd0, grant}, 8'h00);
      chk("to_pulse", {7'd0, tout}, 8'h01);
      chk("to_id0", {7'd0, tid}, 8'h00);
      step();
      chk("to_pulse_end", {7'd0, tout}, 8'd0);
      chk("to_gap", {6'd0, grant}, 8'h00);
      step();
      chk("to_next", {6'd0, grant}, 8'h02);
      req = 2'b01;
      step(); step(); step();
      chk("to_masked", {6'd0, grant}, 8'h00);
      req = 2'b00;
      step();
      req = 2'b01;
      step();
      chk("to_unmask", {6'd0, grant}, 8'h01);

      // release on the boundary cycle
      for (int i = 0; i < 7; i++) step();
      chk("bnd_hold", {6'd0, grant}, 8'h01);
      req = 2'b00;
      step();
      chk("bnd_rel", {6'd0, grant}, 8'h00);
      chk("bnd_nopulse", {7'd0, tout}, 8'd0);
      step();
      chk("bnd_nopulse2", {7'd0, tout}, 8'd0);
      req = 2'b01;
      step();
      chk("bnd_regrant", {6'd0, grant}, 8'h01);
      req = 2'b00;
      step(); step();

      // timeout of master 1
      req = 2'b10;
      step();
      for (int i = 0; i < 8; i++) step();
      chk("to1_pulse", {7'd0, tout}, 8'h01);
      chk("to1_id", {7'd0, tid}, 8'h01);
      step();
      chk("to1_sticky", {7'd0, tid}, 8'h01);
      req = 2'b00;
      step(); step();

      // asynchronous reset mid-grant
      req = 2'b01; m_wr = 2'b01; m_mode = 2'b01; m_valid = 2'b01;
      step();
      chk("ar_grant", {6'd0, grant}, 8'h01);
      chk("ar_mux", {5'd0, wr_bus, mode, mvalid}, 8'h07);
      #20 rst = 1'b1;
      #1;
      chk("ar_clr", {6'd0, grant}, 8'h00);
      chk("ar_mux0", {5'd0, wr_bus, mode, mvalid}, 8'h00);
      chk("ar_tid", {7'd0, tid}, 8'h00);
      #20 rst = 1'b0;
      step();
      chk("ar_regrant", {6'd0, grant}, 8'h01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter for the serial system bus. It sits between two `master_port` instances and the shared bus lines that feed the slave ports. It grants the bus to one master per transaction and muxes that master's outbound serial lines (`wr_bus`, `mode`, `master_valid`) onto the shared bus. It returns the slave-side lines (`rd_bus`, `slave_ready`) only to the granted master, and revokes the grant if a transaction hangs.

## Interface
- `TIMEOUT`, 256: maximum cycles one grant may be held; legal range 4..65535; counter width is `$clog2(TIMEOUT)`.
- `clk`  in  1  bus clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  2  per-master bus request; bit i belongs to master i; held high for the whole transaction.
- `grant`  out  2  one-hot (or zero) registered grant.
- `m_wr_bus`  in  2  per-master serial write line.
- `m_mode`  in  2  per-master mode (1 = write, 0 = read).
- `m_valid`  in  2  per-master `master_valid`.
- `m_rd_bus`  out  2  per-master serial read line.
- `m_ready`  out  2  per-master `slave_ready`.
- `wr_bus`, `mode`, `master_valid`  out  1 each  shared bus lines toward the slaves.
- `rd_bus`, `slave_ready`  in  1 each  shared bus lines from the slaves.
- `timeout`  out  1  one-cycle pulse when a grant is revoked.
- `timeout_id`  out  1  index of the master whose grant was last revoked; sticky until the next timeout.

## Operation
- **FSM states:** IDLE, GRANT, RELEASE.
- **IDLE:**
  - Effective requests are `eff_req = req & ~mask`.
  - If `eff_req` is non-zero, pick a winner, load `grant`, clear the hold counter and go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT:**
  - The hold counter increments every cycle.
  - If `req[g]` is low, go to RELEASE.
  - Else, if the counter equals `TIMEOUT-1`, go to RELEASE, pulse `timeout`, set `timeout_id = g` and set `mask[g]`.
- **RELEASE:**
  - `grant` is zero for exactly one turnaround cycle, then the FSM returns to IDLE.
- **Mask:** `mask[i]` clears on any cycle where `req[i]` is low. A timed-out master must therefore drop `req` for at least one cycle before it is eligible again.
- **Muxing (combinational from the `grant` register):**
  - Shared `wr_bus`, `mode` and `master_valid` take the granted master's lines. With no grant, all three are 0.
  - `m_rd_bus[g]` and `m_ready[g]` follow `rd_bus` and `slave_ready` for the granted master only. All other bits are 0.
- **Simultaneous requests:** arbitration policy (see Configuration).
- **Request changes mid-grant:** a request from the non-granted master during GRANT has no effect until IDLE.
- **Reset mid-transaction:** the grant is dropped immediately (asynchronous) and all shared outputs go to 0. The slave must rely on its own reset.

## Timing
- **Reset values:** `grant=0`, `timeout=0`, `timeout_id=0`, `mask=0`, FSM=IDLE, counter=0, `last=1`. All muxed outputs are 0.
- **Grant latency:** `req` sampled high in IDLE at edge N gives `grant` high after edge N, i.e. 1 cycle.
- **Release latency:** `req` dropping at edge N in GRANT clears `grant` after edge N+1. The next grant appears no earlier than edge N+2.
- **Back-to-back use:** the minimum gap between two grants is 2 cycles (RELEASE + IDLE).
- **Timeout boundary:** the grant lasts exactly `TIMEOUT` cycles. If `req` drops on the same edge the counter hits `TIMEOUT-1`, this is a normal release with no `timeout` pulse.
- **Mux path:** combinational, zero added latency on the serial data lines.

## Configuration
- **`BUS_ARB_ROUND_ROBIN_EN` defined:**
  - Register `last` holds the index of the most recent winner.
  - On a tie, the master other than `last` wins.
  - `last` updates on every IDLE→GRANT transition.
- **`BUS_ARB_ROUND_ROBIN_EN` undefined:**
  - Fixed priority: master 0 always wins ties.
  - `last` is not implemented.

## Test plan
- **Single master:** reset; `req=2'b01` held for 30 cycles, then dropped; master 0 drives write of 0x5A to 0xF234 → `grant=01` one cycle after `req`. Shared `wr_bus` bit stream equals `m_wr_bus[0]`. `grant=00` two edges after `req` falls.
- **Read return path:** master 1 granted for a read; slave drives `rd_bus`/`slave_ready` → `m_rd_bus[1]` and `m_ready[1]` mirror them. `m_rd_bus[0]=0` and `m_ready[0]=0` throughout.
- **Tie handling:** `req=2'b11` asserted continuously; each master drops `req` for 1 cycle after 10 cycles of grant.
  - With the macro: grants alternate 01, 10, 01.
  - Without it: master 0 is granted first, and master 1 only gets the bus when master 0's `req` is low in IDLE.
- **Timeout:** `TIMEOUT=8`; master 0 holds `req` forever → `grant=01` for exactly 8 cycles, a 1-cycle `timeout` pulse, `timeout_id=0`, then master 0 is not regranted until its `req` toggles low. A pending master 1 is granted 2 cycles after revocation.
- **Release at the boundary:** `TIMEOUT=8`; master 0 drops `req` on the 8th grant cycle → no `timeout` pulse, normal RELEASE.
- **Asynchronous reset:** assert `rst` mid-grant between clock edges → `grant`, `wr_bus`, `mode` and `master_valid` go to 0 immediately. After `rst` falls with `req=01`, the grant returns 1 cycle later.
